// File: rtl/cpu_mem_bridge_if.sv
// cpu_mem_bridge_if: word-organised memory port between the bridge (master) and memory (slave).
interface cpu_mem_bridge_if;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  mem_wmask;
   logic [15:0] mem_address;
   logic [15:0] mem_wdata;
   logic        mem_resp;
   logic [15:0] mem_rdata;
   modport master (output mem_read, mem_write, mem_wmask, mem_address, mem_wdata, input mem_resp, mem_rdata);
   modport slave (input mem_read, mem_write, mem_wmask, mem_address, mem_wdata, output mem_resp, mem_rdata);
endinterface

// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: CPU byte/word accesses to a 16-bit word memory; odd words split in two, with timeout.
// Optional CPU_PAGE_WRAP_EN adds cpu_pwrap: the second half of a split word wraps within its page.
module cpu_mem_bridge #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic        cpu_size,
   input  logic [15:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
`ifdef CPU_PAGE_WRAP_EN
   input  logic        cpu_pwrap,
`endif
   output logic [15:0] cpu_rdata,
   output logic        cpu_ready,
   output logic        cpu_err,
   output logic        cpu_busy,
   cpu_mem_bridge_if.master bus
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
   localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES);
   typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;
   state_t state, state_n;
   logic we, size, pwrap, split, expire;
   logic [15:0] addr, wdata, addr2;
   logic rd, wr, rd_n, wr_n, err_n;
   logic [1:0] mask, mask_n;
   logic [15:0] maddr, maddr_n, mwd, mwd_n, rdata_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [7:0] lo, lo_n;
`ifndef CPU_PAGE_WRAP_EN
   assign pwrap = 1'b0;
`endif
   assign split = size & addr[0];
   // Page wrap reproduces the 6502 JMP (indirect) high-byte fetch bug.
   assign addr2 = (pwrap ? {addr[15:8], addr[7:0] + 8'd1} : addr + 16'd1) & 16'hFFFE;
   assign expire = (TIMEOUT_CYCLES != 0) && (cnt + 1'b1 == LIM);
   assign cpu_ready = state == DONE;
   assign cpu_busy = state != IDLE;
   assign bus.mem_read = rd;
   assign bus.mem_write = wr;
   assign bus.mem_wmask = mask;
   assign bus.mem_address = maddr;
   assign bus.mem_wdata = mwd;
   always_comb begin
      state_n = state;
      rd_n = rd;
      wr_n = wr;
      mask_n = mask;
      maddr_n = maddr;
      mwd_n = mwd;
      cnt_n = cnt + 1'b1;
      lo_n = lo;
      rdata_n = cpu_rdata;
      err_n = cpu_err;
      case (state)
         IDLE: if (cpu_req) begin
            state_n = ACC1;
            rd_n = ~cpu_we;
            wr_n = cpu_we;
            mask_n = cpu_addr[0] ? 2'b10 : (cpu_size ? 2'b11 : 2'b01);
            maddr_n = {cpu_addr[15:1], 1'b0};
            mwd_n = (cpu_size & ~cpu_addr[0]) ? cpu_wdata : {2{cpu_wdata[7:0]}};
            cnt_n = '0;
         end
         ACC1, ACC2: if (bus.mem_resp || expire) begin
            rd_n = 1'b0;
            wr_n = 1'b0;
            mask_n = 2'b00;
            maddr_n = 16'h0;
            mwd_n = 16'h0;
            if (bus.mem_resp && state == ACC1 && split) begin
               state_n = ACC2;
               rd_n = ~we;
               wr_n = we;
               mask_n = 2'b01;
               maddr_n = addr2;
               mwd_n = {2{wdata[15:8]}};
               cnt_n = '0;
               lo_n = bus.mem_rdata[15:8];
            end else begin
               state_n = DONE;
               err_n = ~bus.mem_resp;
               rdata_n = !bus.mem_resp ? 16'h0 : state == ACC2 ? {bus.mem_rdata[7:0], lo} :
                         size ? bus.mem_rdata : {8'h00, addr[0] ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0]};
            end
         end
         default: begin
            state_n = IDLE;
            err_n = 1'b0;
         end
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         {rd, wr, mask, maddr, mwd} <= '0;
         {cnt, lo, cpu_rdata, cpu_err} <= '0;
         {we, size, addr, wdata} <= '0;
`ifdef CPU_PAGE_WRAP_EN
         pwrap <= 1'b0;
`endif
      end else begin
         state <= state_n;
         {rd, wr, mask, maddr, mwd} <= {rd_n, wr_n, mask_n, maddr_n, mwd_n};
         {cnt, lo, cpu_rdata, cpu_err} <= {cnt_n, lo_n, rdata_n, err_n};
         if (state == IDLE && cpu_req) begin
            {we, size, addr, wdata} <= {cpu_we, cpu_size, cpu_addr, cpu_wdata};
`ifdef CPU_PAGE_WRAP_EN
            pwrap <= cpu_pwrap;
`endif
         end
      end
   end
endmodule

// File: tb/tb_cpu_mem_bridge.sv
// tb_cpu_mem_bridge: directed tests of cpu_mem_bridge against a byte-array word memory model.
module tb_cpu_mem_bridge;
   logic clk = 1'b0, rst_n = 1'b0;
   logic cpu_req = 1'b0, cpu_we = 1'b0, cpu_size = 1'b0, pw = 1'b0;
   logic [15:0] cpu_addr = 16'h0, cpu_wdata = 16'h0, cpu_rdata;
   logic cpu_ready, cpu_err, cpu_busy;
   int checks = 0, errors = 0;
   int lat = 0, wc = 0;
   logic hang = 1'b0;
   logic [7:0] mem [0:65535] = '{default: 8'h00};
   logic [15:0] la [0:255];
   logic [1:0] lm [0:255];
   logic [15:0] lw [0:255];
   logic [7:0] nlog = 8'd0;
   cpu_mem_bridge_if bus ();
   cpu_mem_bridge #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
`ifdef CPU_PAGE_WRAP_EN
      .cpu_pwrap(pw),
`endif
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err), .cpu_busy(cpu_busy), .bus(bus));
   always #5 clk = ~clk;
   assign bus.mem_resp = (bus.mem_read | bus.mem_write) && !hang && wc == lat;
   assign bus.mem_rdata = {mem[{bus.mem_address[15:1], 1'b1}], mem[{bus.mem_address[15:1], 1'b0}]};
   always @(posedge clk) begin
      wc <= ((bus.mem_read | bus.mem_write) && !bus.mem_resp) ? wc + 1 : 0;
      if ((bus.mem_read | bus.mem_write) && bus.mem_resp) begin
         la[nlog] <= bus.mem_address;
         lm[nlog] <= bus.mem_wmask;
         lw[nlog] <= bus.mem_wdata;
         nlog <= nlog + 8'd1;
         if (bus.mem_write && bus.mem_wmask[0]) mem[{bus.mem_address[15:1], 1'b0}] <= bus.mem_wdata[7:0];
         if (bus.mem_write && bus.mem_wmask[1]) mem[{bus.mem_address[15:1], 1'b1}] <= bus.mem_wdata[15:8];
      end
   end
   // Issues one request from IDLE; n counts edges from the accept edge through the edge raising cpu_ready.
   task automatic access(input logic w, input logic s, input logic [15:0] a, input logic [15:0] d,
                         output int n, output logic [15:0] r, output logic e);
      @(negedge clk);
      while (cpu_busy) @(negedge clk);
      {cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata} = {1'b1, w, s, a, d};
      @(posedge clk); #1;
      cpu_req = 1'b0;
      n = 1;
      while (!cpu_ready && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      r = cpu_rdata;
      e = cpu_err;
   endtask
   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      checks++; if ({cpu_ready, cpu_err, cpu_busy} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {cpu_ready, cpu_err, cpu_busy}); end
      checks++; if (cpu_rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata got %h want 0000", cpu_rdata); end
      checks++; if ({bus.mem_read, bus.mem_write, bus.mem_wmask} !== 4'b0000) begin errors++; $display("FAIL reset_strobes got %b want 0000", {bus.mem_read, bus.mem_write, bus.mem_wmask}); end
      checks++; if ({bus.mem_address, bus.mem_wdata} !== 32'h0) begin errors++; $display("FAIL reset_bus got %h want 0", {bus.mem_address, bus.mem_wdata}); end
      @(negedge clk) rst_n = 1'b1;
   endtask
   task automatic test_byte;
      int n; logic [15:0] r; logic e; logic [7:0] b;
      b = nlog;
      access(1'b1, 1'b0, 16'h0301, 16'h77A5, n, r, e);
      checks++; if (nlog - b !== 8'd1) begin errors++; $display("FAIL byte_wr_count got %0d want 1", nlog - b); end
      checks++; if ({la[b], lm[b], lw[b]} !== {16'h0300, 2'b10, 16'hA5A5}) begin errors++; $display("FAIL byte_wr_odd got %h/%b/%h want 0300/10/a5a5", la[b], lm[b], lw[b]); end
      checks++; if (n !== 2) begin errors++; $display("FAIL byte_wr_latency got %0d want 2", n); end
      access(1'b0, 1'b0, 16'h0301, 16'h0, n, r, e);
      checks++; if ({r, e} !== {16'h00A5, 1'b0}) begin errors++; $display("FAIL byte_rd_odd got %h err %b want 00a5 err 0", r, e); end
      checks++; if (n !== 2) begin errors++; $display("FAIL byte_rd_latency got %0d want 2", n); end
      b = nlog;
      access(1'b1, 1'b0, 16'h0300, 16'h005A, n, r, e);
      checks++; if ({la[b], lm[b], lw[b]} !== {16'h0300, 2'b01, 16'h5A5A}) begin errors++; $display("FAIL byte_wr_even got %h/%b/%h want 0300/01/5a5a", la[b], lm[b], lw[b]); end
      access(1'b0, 1'b0, 16'h0300, 16'h0, n, r, e);
      checks++; if (r !== 16'h005A) begin errors++; $display("FAIL byte_rd_even got %h want 005a", r); end
   endtask
   task automatic test_word;
      int n; logic [15:0] r; logic e; logic [7:0] b;
      b = nlog;
      access(1'b1, 1'b1, 16'h0400, 16'hBEEF, n, r, e);
      checks++; if ({la[b], lm[b], lw[b]} !== {16'h0400, 2'b11, 16'hBEEF}) begin errors++; $display("FAIL word_wr got %h/%b/%h want 0400/11/beef", la[b], lm[b], lw[b]); end
      access(1'b0, 1'b1, 16'h0400, 16'h0, n, r, e);
      checks++; if (nlog - b !== 8'd2) begin errors++; $display("FAIL word_count got %0d want 2", nlog - b); end
      checks++; if (r !== 16'hBEEF) begin errors++; $display("FAIL word_rd got %h want beef", r); end
      checks++; if (n !== 2) begin errors++; $display("FAIL word_latency got %0d want 2", n); end
      lat = 2;
      access(1'b0, 1'b1, 16'h0400, 16'h0, n, r, e);
      lat = 0;
      checks++; if ({n, r} !== {32'd4, 16'hBEEF}) begin errors++; $display("FAIL word_wait got n=%0d %h want n=4 beef", n, r); end
   endtask
   task automatic test_split_read;
      int n; logic [15:0] r; logic e; logic [7:0] b;
      access(1'b1, 1'b0, 16'h02FF, 16'h0034, n, r, e);
      access(1'b1, 1'b0, 16'h0300, 16'h0012, n, r, e);
      b = nlog;
      access(1'b0, 1'b1, 16'h02FF, 16'h0, n, r, e);
      checks++; if (nlog - b !== 8'd2) begin errors++; $display("FAIL split_rd_count got %0d want 2", nlog - b); end
      checks++; if ({la[b], lm[b]} !== {16'h02FE, 2'b10}) begin errors++; $display("FAIL split_rd_acc1 got %h/%b want 02fe/10", la[b], lm[b]); end
      checks++; if ({la[b+8'd1], lm[b+8'd1]} !== {16'h0300, 2'b01}) begin errors++; $display("FAIL split_rd_acc2 got %h/%b want 0300/01", la[b+8'd1], lm[b+8'd1]); end
      checks++; if ({r, e} !== {16'h1234, 1'b0}) begin errors++; $display("FAIL split_rd_data got %h err %b want 1234 err 0", r, e); end
      checks++; if (n !== 3) begin errors++; $display("FAIL split_rd_latency got %0d want 3", n); end
`ifdef CPU_PAGE_WRAP_EN
      pw = 1'b1;
      b = nlog;
      access(1'b0, 1'b1, 16'h02FF, 16'h0, n, r, e);
      pw = 1'b0;
      checks++; if (la[b+8'd1] !== 16'h0200) begin errors++; $display("FAIL pwrap_addr got %h want 0200", la[b+8'd1]); end
      checks++; if (r !== 16'h0034) begin errors++; $display("FAIL pwrap_data got %h want 0034", r); end
`endif
   endtask
   task automatic test_wrap_write;
      int n; logic [15:0] r; logic e; logic [7:0] b;
      access(1'b1, 1'b0, 16'hFFFE, 16'h0011, n, r, e);
      access(1'b1, 1'b0, 16'h0001, 16'h0022, n, r, e);
      b = nlog;
      access(1'b1, 1'b1, 16'hFFFF, 16'hCAFE, n, r, e);
      checks++; if (nlog - b !== 8'd2) begin errors++; $display("FAIL wrap_count got %0d want 2", nlog - b); end
      checks++; if ({la[b], lm[b], lw[b][15:8]} !== {16'hFFFE, 2'b10, 8'hFE}) begin errors++; $display("FAIL wrap_acc1 got %h/%b/%h want fffe/10/fe", la[b], lm[b], lw[b]); end
      checks++; if ({la[b+8'd1], lm[b+8'd1], lw[b+8'd1][7:0]} !== {16'h0000, 2'b01, 8'hCA}) begin errors++; $display("FAIL wrap_acc2 got %h/%b/%h want 0000/01/ca", la[b+8'd1], lm[b+8'd1], lw[b+8'd1]); end
      checks++; if ({mem[16'hFFFE], mem[16'hFFFF], mem[16'h0000], mem[16'h0001]} !== 32'h11FECA22) begin errors++; $display("FAIL wrap_mem got %h want 11feca22", {mem[16'hFFFE], mem[16'hFFFF], mem[16'h0000], mem[16'h0001]}); end
      checks++; if (n !== 3) begin errors++; $display("FAIL wrap_latency got %0d want 3", n); end
   endtask
   task automatic test_timeout;
      int n; logic [15:0] r; logic e; logic [7:0] b;
      hang = 1'b1;
      b = nlog;
      access(1'b0, 1'b1, 16'h02FF, 16'h0, n, r, e);
      hang = 1'b0;
      checks++; if ({e, r} !== {1'b1, 16'h0}) begin errors++; $display("FAIL timeout_err got err %b %h want err 1 0000", e, r); end
      checks++; if (n !== 5) begin errors++; $display("FAIL timeout_latency got %0d want 5", n); end
      checks++; if (nlog !== b) begin errors++; $display("FAIL timeout_no_acc got %0d want 0", nlog - b); end
      access(1'b0, 1'b1, 16'h0400, 16'h0, n, r, e);
      checks++; if ({e, r, n} !== {1'b0, 16'hBEEF, 32'd2}) begin errors++; $display("FAIL timeout_recover got err %b %h n=%0d want err 0 beef n=2", e, r, n); end
   endtask
   task automatic test_back_to_back;
      int n; logic [15:0] r; logic e;
      access(1'b0, 1'b1, 16'h0400, 16'h0, n, r, e);
      cpu_req = 1'b1;
      @(posedge clk); #1;
      checks++; if (cpu_busy !== 1'b0) begin errors++; $display("FAIL b2b_done_ignored got busy %b want 0", cpu_busy); end
      @(posedge clk); #1;
      cpu_req = 1'b0;
      checks++; if (cpu_busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy %b want 1", cpu_busy); end
      n = 0;
      while (!cpu_ready && n < 40) begin @(posedge clk); #1; n++; end
      checks++; if ({cpu_ready, cpu_rdata} !== {1'b1, 16'hBEEF}) begin errors++; $display("FAIL b2b_data got ready %b %h want ready 1 beef", cpu_ready, cpu_rdata); end
   endtask
   task automatic test_reset_mid;
      int rdy = 0;
      hang = 1'b1;
      @(negedge clk);
      while (cpu_busy) @(negedge clk);
      {cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata} = {1'b1, 1'b1, 1'b1, 16'h1001, 16'h5566};
      @(posedge clk); #1;
      cpu_req = 1'b0;
      checks++; if ({bus.mem_write, bus.mem_wmask} !== 3'b110) begin errors++; $display("FAIL rst_mid_acc1 got %b want 110", {bus.mem_write, bus.mem_wmask}); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({bus.mem_read, bus.mem_write, cpu_ready, cpu_busy} !== 4'b0000) begin errors++; $display("FAIL rst_mid_drop got %b want 0000", {bus.mem_read, bus.mem_write, cpu_ready, cpu_busy}); end
      @(negedge clk) rst_n = 1'b1;
      hang = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         if (cpu_ready || cpu_busy) rdy++;
      end
      checks++; if (rdy !== 0) begin errors++; $display("FAIL rst_mid_idle got %0d active cycles want 0", rdy); end
      checks++; if ({mem[16'h1000], mem[16'h1001]} !== 16'h0) begin errors++; $display("FAIL rst_mid_mem got %h want 0000", {mem[16'h1000], mem[16'h1001]}); end
   endtask
   initial begin
      test_reset;
      test_byte;
      test_word;
      test_split_read;
      test_wrap_write;
      test_timeout;
      test_back_to_back;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
